// File: rtl/asp_irq_aggregator.sv
// Interrupt aggregator: per-line edge/level capture into sticky STATUS, masked by ENABLE,
// gated by a global enable, and exposed through a 64-bit Avalon-MM CSR block.
module asp_irq_aggregator #(
    parameter int unsigned NUM_IRQ_LINES  = 4,
    parameter logic [31:0] EDGE_MODE_MASK = 32'h0,
    parameter int unsigned CSR_ADDR_WIDTH = 3,
    parameter logic [15:0] VERSION        = 16'h0001
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_IRQ_LINES-1:0]  irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0] avmm_address,
    input  logic                      avmm_read,
    input  logic                      avmm_write,
    input  logic [63:0]               avmm_writedata,
    input  logic [7:0]                avmm_byteenable,
    output logic [63:0]               avmm_readdata,
    output logic                      avmm_readdatavalid,
    output logic                      avmm_waitrequest,
    output logic                      irq_out
);

    localparam int unsigned N = NUM_IRQ_LINES;
    localparam logic [N-1:0] EDGE_LINES = EDGE_MODE_MASK[N-1:0];

    typedef enum logic [2:0] {
        CSR_STATUS  = 3'd0,
        CSR_ENABLE  = 3'd1,
        CSR_PENDING = 3'd2,
        CSR_FORCE   = 3'd3,
        CSR_CTRL    = 3'd4,
        CSR_PARAMS  = 3'd5
    } csr_e;

    logic [N-1:0] status;
    logic [N-1:0] enable;
    logic [N-1:0] irq_prev;
    logic         global_en;

    logic [31:0]  addr_ext;
    logic         sel_status;
    logic         sel_enable;
    logic         sel_pending;
    logic         sel_force;
    logic         sel_ctrl;
    logic         sel_params;

    logic [63:0]  lane_mask;
    logic [63:0]  wr_bits;
    logic [N-1:0] wr_mask;
    logic [N-1:0] set_events;
    logic [N-1:0] w1c;
    logic [N-1:0] w1s;
    logic [N-1:0] status_next;
    logic [N-1:0] enable_next;
    logic         global_en_next;
    logic [63:0]  rd_word;
    logic [63:0]  params_word;
    logic         unused_wr;

    assign avmm_waitrequest = 1'b0;

    // Zero-extend so narrow address buses never alias onto a defined register.
    assign addr_ext    = 32'(avmm_address);
    assign sel_status  = (addr_ext == 32'(CSR_STATUS));
    assign sel_enable  = (addr_ext == 32'(CSR_ENABLE));
    assign sel_pending = (addr_ext == 32'(CSR_PENDING));
    assign sel_force   = (addr_ext == 32'(CSR_FORCE));
    assign sel_ctrl    = (addr_ext == 32'(CSR_CTRL));
    assign sel_params  = (addr_ext == 32'(CSR_PARAMS));

    always_comb begin
        lane_mask = '0;
        for (int unsigned b = 0; b < 8; b++) begin
            lane_mask[b*8 +: 8] = {8{avmm_byteenable[b]}};
        end
    end

    assign wr_bits   = avmm_writedata & lane_mask;
    assign wr_mask   = lane_mask[N-1:0];
    assign unused_wr = ^wr_bits[63:N];

    assign set_events = (EDGE_LINES & irq_in & ~irq_prev) | (~EDGE_LINES & irq_in);
    assign w1c = (avmm_write && sel_status) ? wr_bits[N-1:0] : '0;
    assign w1s = (avmm_write && sel_force)  ? wr_bits[N-1:0] : '0;

    // Clear is applied first so any coincident set event wins.
    assign status_next = (status & ~w1c) | set_events | w1s;

    always_comb begin
        enable_next    = enable;
        global_en_next = global_en;
        if (avmm_write && sel_enable) begin
            enable_next = (enable & ~wr_mask) | wr_bits[N-1:0];
        end
        if (avmm_write && sel_ctrl && avmm_byteenable[0]) begin
            global_en_next = wr_bits[0];
        end
    end

    always_comb begin
        params_word        = '0;
        params_word[7:0]   = 8'(NUM_IRQ_LINES);
        params_word[31:16] = VERSION;
    end

    always_comb begin
        rd_word = '0;
        if (sel_status) begin
            rd_word[N-1:0] = status;
        end else if (sel_enable) begin
            rd_word[N-1:0] = enable;
        end else if (sel_pending) begin
            rd_word[N-1:0] = status & enable;
        end else if (sel_ctrl) begin
            rd_word[0] = global_en;
        end else if (sel_params) begin
            rd_word = params_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status    <= '0;
            enable    <= '0;
            irq_prev  <= '0;
            global_en <= 1'b0;
        end else begin
            status    <= status_next;
            enable    <= enable_next;
            irq_prev  <= irq_in;
            global_en <= global_en_next;
        end
    end

    // Derived from registered state, so irq_out trails any STATUS/ENABLE/CTRL change by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_out <= 1'b0;
        end else begin
            irq_out <= global_en & (|(status & enable));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            avmm_readdata      <= '0;
            avmm_readdatavalid <= 1'b0;
        end else begin
            avmm_readdatavalid <= avmm_read;
            if (avmm_read) begin
                avmm_readdata <= rd_word;
            end
        end
    end

endmodule

// File: tb/tb_asp_irq_aggregator.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a behavioural register model.
module tb_asp_irq_aggregator;

    localparam int N = 4;
    localparam logic [N-1:0] EDGE = 4'b0001;
    localparam logic [63:0] PARAMS_EXP = {32'h0, 16'h0001, 8'h00, 8'(N)};

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [N-1:0]  irq_in = '0;
    logic [2:0]    avmm_address = '0;
    logic          avmm_read = 1'b0;
    logic          avmm_write = 1'b0;
    logic [63:0]   avmm_writedata = '0;
    logic [7:0]    avmm_byteenable = '0;
    logic [63:0]   avmm_readdata;
    logic          avmm_readdatavalid;
    logic          avmm_waitrequest;
    logic          irq_out;

    int checks = 0;
    int errors = 0;
    logic checking = 1'b0;

    asp_irq_aggregator #(
        .NUM_IRQ_LINES (4),
        .EDGE_MODE_MASK(32'h1),
        .CSR_ADDR_WIDTH(3),
        .VERSION       (16'h0001)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .irq_in            (irq_in),
        .avmm_address      (avmm_address),
        .avmm_read         (avmm_read),
        .avmm_write        (avmm_write),
        .avmm_writedata    (avmm_writedata),
        .avmm_byteenable   (avmm_byteenable),
        .avmm_readdata     (avmm_readdata),
        .avmm_readdatavalid(avmm_readdatavalid),
        .avmm_waitrequest  (avmm_waitrequest),
        .irq_out           (irq_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] status;
        logic [N-1:0] en;
        logic [N-1:0] prev;
        logic         gen;
        logic         irq;
        logic         rv;
        logic [63:0]  rd;
    } model_t;

    model_t m;

    function automatic logic [63:0] reg_value(model_t s, logic [2:0] a);
        case (a)
            3'd0:    return 64'(s.status);
            3'd1:    return 64'(s.en);
            3'd2:    return 64'(s.status & s.en);
            3'd4:    return 64'(s.gen);
            3'd5:    return PARAMS_EXP;
            default: return 64'h0;
        endcase
    endfunction

    // One clock of the register-level behaviour: reads see pre-write values, set beats clear.
    function automatic model_t step(model_t s, logic [N-1:0] irq, logic rd, logic wr,
                                    logic [2:0] a, logic [63:0] wd, logic [7:0] be);
        model_t n;
        logic lane;
        logic set;
        n = s;
        n.rv = rd;
        if (rd) n.rd = reg_value(s, a);
        n.irq = s.gen && ((s.status & s.en) != '0);
        for (int i = 0; i < N; i++) begin
            lane = wr && be[i/8];
            set  = EDGE[i] ? (irq[i] && !s.prev[i]) : irq[i];
            if (lane && a == 3'd3 && wd[i]) set = 1'b1;
            if (lane && a == 3'd0 && wd[i]) n.status[i] = 1'b0;
            if (set) n.status[i] = 1'b1;
            if (lane && a == 3'd1) n.en[i] = wd[i];
        end
        if (wr && be[0] && a == 3'd4) n.gen = wd[0];
        n.prev = irq;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else m <= step(m, irq_in, avmm_read, avmm_write, avmm_address, avmm_writedata, avmm_byteenable);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking && !reset) begin
            check("model_irq_out", 64'(irq_out), 64'(m.irq));
            check("model_rdvalid", 64'(avmm_readdatavalid), 64'(m.rv));
            check("model_waitreq", 64'(avmm_waitrequest), 64'h0);
            if (m.rv) check("model_readdata", avmm_readdata, m.rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [2:0] a, output logic [63:0] d);
        avmm_read = 1'b1;
        avmm_address = a;
        cyc();
        avmm_read = 1'b0;
        check("rd_valid", 64'(avmm_readdatavalid), 64'h1);
        d = avmm_readdata;
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] wd, input logic [7:0] be);
        avmm_write = 1'b1;
        avmm_address = a;
        avmm_writedata = wd;
        avmm_byteenable = be;
        cyc();
        avmm_write = 1'b0;
        avmm_byteenable = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;

        #2 reset = 1'b1;
        #1;
        check("reset_irq_out", 64'(irq_out), 64'h0);
        check("reset_rdvalid", 64'(avmm_readdatavalid), 64'h0);
        check("reset_readdata", avmm_readdata, 64'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        checking = 1'b1;
        cyc();

        rd(3'd5, d);
        check("params", d, 64'h0000_0000_0001_0004);
        cyc();
        check("rdvalid_one_cycle", 64'(avmm_readdatavalid), 64'h0);

        wr(3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        rd(3'd1, d);
        check("enable_upper_bits", d, 64'hF);
        wr(3'd1, 64'h0, 8'hFE);
        rd(3'd1, d);
        check("enable_byte_lane", d, 64'hF);
        wr(3'd1, 64'h0, 8'hFF);

        irq_in[0] = 1'b1;
        cyc();
        irq_in[0] = 1'b0;
        wr(3'd1, 64'h1, 8'hFF);
        wr(3'd4, 64'h1, 8'hFF);
        rd(3'd0, d);
        check("edge_status", d, 64'h1);
        check("edge_irq_out", 64'(irq_out), 64'h1);
        wr(3'd0, 64'h1, 8'hFF);
        check("irq_out_lag", 64'(irq_out), 64'h1);
        cyc();
        check("irq_out_cleared", 64'(irq_out), 64'h0);
        rd(3'd0, d);
        check("w1c_status", d, 64'h0);

        irq_in[2] = 1'b1;
        cyc();
        wr(3'd0, 64'h4, 8'hFF);
        rd(3'd0, d);
        check("level_w1c_held", d, 64'h4);
        irq_in[2] = 1'b0;
        cyc();
        wr(3'd0, 64'h4, 8'hFF);
        rd(3'd0, d);
        check("level_w1c_dropped", d, 64'h0);

        irq_in[0] = 1'b1;
        wr(3'd0, 64'h1, 8'hFF);
        irq_in[0] = 1'b0;
        rd(3'd0, d);
        check("set_beats_clear", d, 64'h1);

        wr(3'd0, 64'hF, 8'hFF);
        wr(3'd1, 64'h0, 8'hFF);
        wr(3'd3, 64'h8, 8'h00);
        rd(3'd0, d);
        check("force_no_lane", d, 64'h0);
        wr(3'd3, 64'h8, 8'h01);
        rd(3'd0, d);
        check("force_status", d, 64'h8);
        rd(3'd2, d);
        check("force_pending", d, 64'h0);
        check("force_irq_out", 64'(irq_out), 64'h0);
        rd(3'd3, d);
        check("force_reads_zero", d, 64'h0);

        for (int k = 0; k < 3000; k++) begin
            irq_in          = N'($urandom & $urandom & $urandom);
            avmm_read       = ($urandom_range(0, 1) == 1);
            avmm_write      = ($urandom_range(0, 4) < 2);
            avmm_address    = 3'($urandom_range(0, 7));
            avmm_writedata  = {$urandom, $urandom};
            avmm_byteenable = 8'($urandom);
            cyc();
        end
        irq_in = '0;
        avmm_read = 1'b0;
        avmm_write = 1'b0;
        cyc();

        wr(3'd1, 64'hF, 8'hFF);
        wr(3'd4, 64'h1, 8'hFF);
        wr(3'd3, 64'h1, 8'h01);
        cyc();
        cyc();
        check("pre_reset_irq_out", 64'(irq_out), 64'h1);
        avmm_read = 1'b1;
        avmm_address = 3'd0;
        cyc();
        @(negedge clk) reset = 1'b1;
        #1;
        check("midread_irq_out", 64'(irq_out), 64'h0);
        check("midread_rdvalid", 64'(avmm_readdatavalid), 64'h0);
        check("midread_readdata", avmm_readdata, 64'h0);
        avmm_read = 1'b0;
        irq_in = 4'b0010;
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        cyc();
        check("post_reset_rdvalid", 64'(avmm_readdatavalid), 64'h0);
        rd(3'd0, d);
        check("level_after_reset", d, 64'h2);
        irq_in = '0;
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/asp_irq_aggregator.md
ASP_IRQ_AGGREGATOR -- requirements
Module: asp_irq_aggregator

Interface
REQ-001 Parameter NUM_IRQ_LINES, default 4: number of interrupt sources; legal range 1..32.
REQ-002 Parameter EDGE_MODE_MASK, default 32'h0: per-line mode; bit=1 rising-edge, bit=0 level.
REQ-003 Parameter CSR_ADDR_WIDTH, default 3: 64-bit-word CSR address width.
REQ-004 Parameter VERSION, default 16'h0001: value reported in PARAMS[31:16].
REQ-005 clk  in  1  sole clock; all I/O synchronous to it.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 irq_in  in  NUM_IRQ_LINES  interrupt sources, synchronous to clk.
REQ-008 avmm_address  in  CSR_ADDR_WIDTH  64-bit word address.
REQ-009 avmm_read  in  1  read request.
REQ-010 avmm_write  in  1  write request.
REQ-011 avmm_writedata  in  64  write data.
REQ-012 avmm_byteenable  in  8  byte lanes for writes.
REQ-013 avmm_readdata  out  64  read data.
REQ-014 avmm_readdatavalid  out  1  read response strobe.
REQ-015 avmm_waitrequest  out  1  tied 0; every command is accepted in the cycle presented.
REQ-016 irq_out  out  1  aggregated, registered interrupt to host.

Function
REQ-017 CSR map (word address): 0 STATUS (RO; W1C), 1 ENABLE (RW), 2 PENDING (RO = STATUS & ENABLE), 3 FORCE (WO; W1S into STATUS; reads 0), 4 CTRL (bit0 global_en, RW), 5 PARAMS (RO: [7:0]=NUM_IRQ_LINES, [31:16]=VERSION); other addresses read 0, writes ignored.
REQ-018 Bits >= NUM_IRQ_LINES in STATUS/ENABLE/PENDING SHALL read 0 and ignore writes.
REQ-019 Writes SHALL honour avmm_byteenable per byte lane for all writable registers, including W1C and W1S.
REQ-020 Read latency SHALL be exactly 1 cycle: readdatavalid high the cycle after avmm_read, with readdata holding the register value sampled at the command cycle.
REQ-021 avmm_read and avmm_write in the same cycle: write performed, read also returned (pre-write value) with readdatavalid.
REQ-022 Edge line: STATUS bit set the cycle after irq_in goes 0->1 (previous-value register, reset 0).
REQ-023 Level line: STATUS bit set every cycle irq_in is 1; W1C while input still 1 leaves bit set.
REQ-024 Set event (edge, level, or FORCE) coincident with W1C on same bit: set wins, bit stays 1.
REQ-025 STATUS bits are sticky: cleared only by W1C or reset.
REQ-026 irq_out SHALL be a register equal to global_en & |PENDING, updated one cycle after any STATUS/ENABLE/CTRL change.
REQ-027 Line asserted while ENABLE bit is 0 SHALL still set STATUS; enabling later raises irq_out the cycle after the ENABLE write.
REQ-028 No internal state machine beyond registers; no combinational path from irq_in or avmm inputs to any output.

Reset
REQ-029 On reset assertion, asynchronously: STATUS=0, ENABLE=0, global_en=0, edge history=0, irq_out=0, avmm_readdata=0, avmm_readdatavalid=0.
REQ-030 Reset asserted mid-read SHALL suppress that read's readdatavalid; level inputs high at deassertion set STATUS on the first clock after.

Verification
REQ-031 Reset, then read PARAMS -> readdata=64'h0000_0000_0001_0004, readdatavalid exactly 1 cycle after read.
REQ-032 NUM_IRQ_LINES=4, EDGE_MODE_MASK=4'b0001: pulse irq_in[0] for 1 cycle, ENABLE=1, CTRL=1 -> STATUS=1, irq_out=1; W1C 1 -> STATUS=0, irq_out 0 next cycle.
REQ-033 Level line 2 held high, W1C 4 -> STATUS[2] remains 1; drop irq_in[2] then W1C 4 -> STATUS[2]=0.
REQ-034 Edge on line 0 in same cycle as W1C of bit 0 -> STATUS[0]=1 after the cycle.
REQ-035 FORCE write 64'h8 with byteenable 8'h00 -> STATUS unchanged; with 8'h01 -> STATUS[3]=1, PENDING=0 while ENABLE=0, irq_out=0.
REQ-036 With irq_out=1 and a read outstanding, assert reset -> irq_out, readdatavalid, STATUS all 0 immediately, no response after release.
